// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in one bit
// per clock, LSB first, using a single full-adder slice and a carry flop.
//
// Timing: the accept edge loads the operands; the next WIDTH edges each
// process one bit (bit 0 first). The edge that processes bit WIDTH-1
// publishes the result and enters DONE. The block is back in IDLE one
// edge later, so consecutive starts are WIDTH+2 cycles apart.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   begin an addition (sampled only while ready=1)
//   a, b     in   WIDTH-bit operands, captured on the accept edge
//   c_in     in   carry-in, captured on the accept edge
//   ready    out  high in IDLE
//   busy     out  high in ADD
//   done     out  one-cycle pulse in DONE
//   sum      out  WIDTH-bit result of the last completed addition
//   c_out    out  carry-out of the last completed addition
//   overflow out  two's-complement overflow of the last completed addition
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // One extra bit over what WIDTH-1 needs, so the counter can never wrap
    // inside an operation.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;

    // Full-adder slice on the current LSBs.
    logic bit_a;
    logic bit_b;
    logic s_bit;
    logic carry_bit;
    logic last_bit;

    assign bit_a     = a_sh_reg[0];
    assign bit_b     = b_sh_reg[0];
    assign s_bit     = bit_a ^ bit_b ^ carry_reg;
    assign carry_bit = (bit_a & bit_b) | (carry_reg & (bit_a ^ bit_b));
    assign last_bit  = (cnt_reg == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, result shifter, carry, counter and the
    // published result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= c_in;
                        cnt_reg   <= '0;
                    end
                end
                ADD: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    res_reg   <= {s_bit, res_reg[WIDTH-1:1]};
                    carry_reg <= carry_bit;
                    cnt_reg   <= cnt_reg + CNT_ONE;
                    if (last_bit) begin
                        // carry_reg still holds the carry into the MSB here,
                        // which is what the overflow rule needs.
                        sum_reg   <= {s_bit, res_reg[WIDTH-1:1]};
                        c_out_reg <= carry_bit;
                        ovf_reg   <= carry_bit ^ carry_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = sum_reg;
    assign c_out    = c_out_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         c_in  = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition; returns {overflow, c_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        return {ovf, full};
    endfunction

    // Wait for ready, issue one addition, return cycles from accept edge to done.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          output int lat);
        for (int k = 0; k < 20 && !ready; k++) begin
            @(posedge clk); #1;
        end
        a = oa; b = ob; c_in = oc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status got rdy/busy/done=%b want 100", {ready, busy, done});
        end
        checks++;
        if ({overflow, c_out, sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ovf=%b cout=%b sum=%h want 0", overflow, c_out, sum);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2*W:0] vec [5];
        logic [W+1:0] exp;
        int lat;
        vec[0] = {8'h5A, 8'h3C, 1'b0};
        vec[1] = {8'hFF, 8'h01, 1'b0};
        vec[2] = {8'h00, 8'h00, 1'b1};
        vec[3] = {8'h80, 8'h80, 1'b0};
        vec[4] = {8'hFF, 8'hFF, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(vec[i][2*W:W+1], vec[i][W:1], vec[i][0], lat);
            exp = model(vec[i][2*W:W+1], vec[i][W:1], vec[i][0]);
            checks++;
            if (lat != W) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, W);
            end
            checks++;
            if ({overflow, c_out, sum} !== exp) begin
                errors++;
                $display("FAIL directed_result[%0d] got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                         i, overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] exp;
        int lat;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, lat);
            exp = model(ra, rb, rc);
            checks++;
            if (lat != W || {overflow, c_out, sum} !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h c=%b got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d ovf=%b cout=%b sum=%h",
                         i, ra, rb, rc, lat, overflow, c_out, sum, W, exp[W+1], exp[W], exp[W-1:0]);
            end
        end
    endtask

    // Second start pulse with new operands mid-ADD must be ignored.
    task automatic test_start_ignored();
        logic [W+1:0] exp;
        int lat;
        bit seen;
        run_op(8'h11, 8'h22, 1'b0, lat);
        @(posedge clk); #1;
        a = 8'h7F; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp = model(8'h7F, 8'h01, 1'b0);
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                checks++;
                if (k != W) begin
                    errors++;
                    $display("FAIL ignore_latency got %0d want %0d", k, W);
                end
                break;
            end
            checks++;
            if (sum !== 8'h33) begin
                errors++;
                $display("FAIL ignore_sum_hold cycle %0d got sum=%h want 33", k, sum);
            end
            start = (k == 3);
            if (k == 3) begin
                a = W'($urandom); b = W'($urandom); c_in = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || {overflow, c_out, sum} !== exp) begin
            errors++;
            $display("FAIL ignore_result got done=%b ovf=%b cout=%b sum=%h want done=1 ovf=%b cout=%b sum=%h",
                     seen, overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ca, cb;
        logic         cc;
        logic [W+1:0] exp;
        int last_done;
        int ndone;
        for (int k = 0; k < 20 && !ready; k++) begin
            @(posedge clk); #1;
        end
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        a = ca; b = cb; c_in = cc; start = 1'b1;
        last_done = -1;
        ndone = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(posedge clk); #1;
            checks++;
            if (ready && busy) begin
                errors++;
                $display("FAIL b2b_overlap cycle %0d got ready=1 busy=1 want not both", cyc);
            end
            if (done) begin
                exp = model(ca, cb, cc);
                checks++;
                if (ready !== 1'b0 || {overflow, c_out, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_done cycle %0d got ready=%b ovf=%b cout=%b sum=%h want ready=0 ovf=%b cout=%b sum=%h",
                             cyc, ready, overflow, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing got %0d want %0d", cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                ndone++;
                ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
                a = ca; b = cb; c_in = cc;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone < 5) begin
            errors++;
            $display("FAIL b2b_count got %0d done pulses want >=5", ndone);
        end
    endtask

    task automatic test_reset_abort();
        logic [W+1:0] exp;
        int lat;
        run_op(8'h12, 8'h34, 1'b0, lat);
        for (int k = 0; k < 20 && !ready; k++) begin
            @(posedge clk); #1;
        end
        a = 8'hAA; b = 8'h0F; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({ready, busy, done} !== 3'b100 || {overflow, c_out, sum} !== '0) begin
                errors++;
                $display("FAIL abort_state cycle %0d got rdy/busy/done=%b ovf=%b cout=%b sum=%h want 100 and zeros",
                         k, {ready, busy, done}, overflow, c_out, sum);
            end
        end
        rst_n = 1'b1;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        exp = model(8'h5A, 8'h3C, 1'b0);
        checks++;
        if (lat != W || {overflow, c_out, sum} !== exp) begin
            errors++;
            $display("FAIL abort_restart got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d ovf=%b cout=%b sum=%h",
                     lat, overflow, c_out, sum, W, exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; it is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an addition; sampled only when ready=1.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, operands; captured on the accepting edge.
REQ-006 The block SHALL have port c_in, input, 1 bit, carry-in; captured on the accepting edge.
REQ-007 The block SHALL have port ready, output, 1 bit, high only in IDLE.
REQ-008 The block SHALL have port busy, output, 1 bit, high only in ADD.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits, result of the last completed addition.
REQ-011 The block SHALL have port c_out, output, 1 bit, carry-out of the last completed addition.
REQ-012 The block SHALL have port overflow, output, 1 bit, two's-complement overflow of the last completed addition.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-014 In IDLE with start=1 at an edge (the accept edge E0), the block SHALL load a and b into shift registers, load the carry flop with c_in, clear the bit counter to 0, and enter ADD.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with no register change.
REQ-016 On each edge in ADD, the block SHALL compute one full-adder bit from (LSB of the a shift register, LSB of the b shift register, carry flop): s = a^b^c, carry = (a&b)|(c&(a^b)).
REQ-017 On each ADD edge, the block SHALL shift the operand registers right by one and shift s into the MSB of an internal result register.
REQ-018 On each ADD edge, the block SHALL update the carry flop and increment the counter.
REQ-019 On the ADD edge that processes bit WIDTH-1 (edge E_WIDTH), the block SHALL transfer the completed result to sum and the final carry to c_out.
REQ-020 On edge E_WIDTH, the block SHALL set overflow to (final carry XOR carry into bit WIDTH-1), and enter DONE.
REQ-021 Latency SHALL be as follows: done is high for exactly the one cycle following E_WIDTH; from DONE the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-022 Minimum start-to-start spacing SHALL be WIDTH+2 cycles.
REQ-023 start SHALL be ignored in ADD and DONE, with no effect on operands, counter or outputs.
REQ-024 a, b and c_in SHALL be don't-care except at the accept edge; changes during ADD SHALL NOT affect the result.
REQ-025 sum, c_out and overflow SHALL hold their previous values throughout ADD and update only at E_WIDTH.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap within an operation.
REQ-027 The result SHALL equal (a + b + c_in) mod 2^WIDTH, with c_out being bit WIDTH of the full sum.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL enter IDLE and clear sum, c_out, overflow, the carry flop, the counter and the shift registers to 0.
REQ-029 While in reset the outputs SHALL be: ready=1, busy=0, done=0; rst_n has priority over start.
REQ-030 Reset asserted during ADD or DONE SHALL abort the operation with no done pulse, and outputs SHALL read 0.
REQ-031 After rst_n returns high, the first start SHALL be accepted on the next edge.

Verification
REQ-032 With WIDTH=8, a=0x5A, b=0x3C, c_in=0, the bench SHALL check that done occurs 8 cycles after the accept edge with sum=0x96, c_out=0 and overflow=1.
REQ-033 With a=0xFF, b=0x01, c_in=0, the bench SHALL check sum=0x00, c_out=1, overflow=0; with a=0x00, b=0x00, c_in=1, it SHALL check sum=0x01, c_out=0, overflow=0.
REQ-034 With a=0x80, b=0x80, c_in=0, the bench SHALL check sum=0x00, c_out=1, overflow=1.
REQ-035 The bench SHALL pulse start with new operands mid-ADD and check that the result matches the first operands and that sum is unchanged until done.
REQ-036 The bench SHALL hold start high continuously and check that done pulses every 10 cycles (WIDTH+2), that busy never overlaps ready, and that ready=0 in DONE.
REQ-037 The bench SHALL drop rst_n at the third ADD cycle and check that there is no done pulse, sum=0, ready=1, and that the next start completes correctly.
